nor_bus_sequencer: RTL and testbench
====================================

// Module: nor_bus_sequencer
// PURPOSE
//  Sequences single-word read/program bus cycles on the parallel NOR (NR1B-SQT56) from a simple req/ack port.
//  Sits between the bridge's NOR wishbone slave and the top-level NOR pins (addr/DQ/CE/OE/WE/RY_BY).
//  Generates setup/strobe/hold timing from cycle counters and optionally waits for RY/BY after a write.
// PARAMETERS
//  ADDR_W   26  NOR address width
//  DATA_W   16  NOR data width (word mode, BYTE# tied high)
//  T_SETUP  2   cycles CE low / addr / data stable before strobe (>=1)
//  T_RD     24  cycles OE# low for a read access (>=1)
//  T_WP     12  cycles WE# low for a write pulse (>=1)
//  T_HOLD   2   cycles after strobe release before CE# rises (>=1)
//  T_BUSY   48  cycles after write hold before RY/BY is sampled (tWB cover, >=1)
//  T_RY_TO  2400000  RY/BY timeout in cycles (used only with NOR_RY_TIMEOUT_EN)
// PORTS
//  clk_i          in   1       system clock (240 MHz PLL)
//  reset_i        in   1       synchronous active-high reset
//  req_i          in   1       request; accepted only in IDLE (busy_o=0)
//  req_we_i       in   1       1=write/program cycle, 0=read
//  req_ry_wait_i  in   1       write only: wait for RY/BY ready before ack
//  req_addr_i     in   ADDR_W  word address, latched at accept
//  req_data_i     in   DATA_W  write data, latched at accept
//  ack_o          out  1       one-cycle completion pulse
//  rdata_o        out  DATA_W  read data; valid when ack_o, held until next read sample
//  err_o          out  1       with ack_o: RY/BY timeout occurred
//  busy_o         out  1       high in every state except IDLE
//  nor_addr_o     out  ADDR_W  NOR address pins
//  nor_data_i     in   DATA_W  NOR DQ input
//  nor_data_o     out  DATA_W  NOR DQ output
//  nor_data_oe    out  1       DQ output enable
//  nor_ry_i       in   1       RY/BY# (async; 2-FF synchronised internally; 1=ready)
//  nor_ce_o, nor_oe_o, nor_we_o  out 1 each  active-low strobes
// BEHAVIOUR
//  Reset: ce/oe/we=1, nor_data_oe=0, nor_addr_o=0, nor_data_o=0, ack_o=0, err_o=0, busy_o=0, rdata_o=0, state IDLE.
//  Reset asserted mid-cycle: all outputs return to reset values at the next edge; no ack issued.
//  All outputs registered. States: IDLE->SETUP->STROBE->HOLD->[BUSYDLY->RYWAIT]->DONE->IDLE.
//  IDLE: req_i=1 at edge latches addr/data/we/ry_wait into nor_addr_o/nor_data_o; ->SETUP.
//  SETUP (T_SETUP cyc): ce=0; nor_data_oe=req_we. ->STROBE.
//  STROBE: read oe=0 for T_RD cyc, nor_data_i captured into rdata_o at end of last STROBE cycle; write we=0 for T_WP cyc.
//  HOLD (T_HOLD cyc): oe=we=1, ce=0, data_oe held, addr held. Exit: write&ry_wait ->BUSYDLY else ->DONE.
//  BUSYDLY (T_BUSY cyc): ce=1, data_oe=0. ->RYWAIT. RYWAIT: exits to DONE on first cycle synced RY=1.
//  DONE: ce=1, data_oe=0, ack_o=1 for exactly one cycle; ->IDLE. Next request accepted no earlier than the IDLE cycle.
//  Latency (accept edge = cycle 0): read ack at cycle T_SETUP+T_RD+T_HOLD+1; write w/o wait at T_SETUP+T_WP+T_HOLD+1.
//  req_i while busy_o=1 is ignored (not queued); req_i held high after ack starts a new cycle from IDLE.
//  nor_addr_o/nor_data_o hold last value in IDLE; oe and we never low simultaneously; data_oe never high with oe=0.
//  Counters: single down-counter sized for max(T_*) (clog2); reloaded on every state entry.
// CONFIGURATION
//  NOR_RY_TIMEOUT_EN defined: RYWAIT counts cycles; reaching T_RY_TO ->DONE with err_o=1 alongside ack_o.
//   err_o clears on the next accept; a ready before timeout gives err_o=0.
//  Not defined: RYWAIT waits indefinitely; err_o tied 0; no timeout counter synthesised.
// TESTING (T_SETUP=2, T_RD=4, T_WP=3, T_HOLD=1, T_BUSY=5, T_RY_TO=20)
//  Read addr 0x12345, DQ=0xBEEF -> ce low 7 cyc, oe low 4 cyc, ack at cycle 8, rdata_o=0xBEEF, nor_data_oe=0 throughout.
//  Write addr 0x00AAA data 0x00AA, no wait -> data_oe=1 cyc 1-6, we low cyc 3-5, ack at cycle 7, ce high at ack.
//  Write with ry_wait, RY low 10 cyc after hold -> ack 2 sync cycles after RY rises, err_o=0.
//  Timeout (macro on), RY stuck low -> ack with err_o=1 after BUSYDLY+20; next read gives err_o=0.
//  req_i held high, second req pulsed during STROBE -> back-to-back cycles only; mid-cycle req dropped, one ack per accept.
//  reset_i pulsed during STROBE of a write -> next edge ce/we=1, data_oe=0, no ack; subsequent read completes normally.

Source files
------------

// File: rtl/nor_bus_sequencer.sv
// Single-word read/program sequencer for a parallel NOR flash, driven from a req/ack port.
// Define NOR_RY_TIMEOUT_EN to bound the RY/BY wait with a timeout that reports through err_o.
module nor_bus_sequencer #(
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 16,
    parameter int T_SETUP = 2,
    parameter int T_RD    = 24,
    parameter int T_WP    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_BUSY  = 48,
    parameter int T_RY_TO = 2400000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_i,
    input  logic              req_we_i,
    input  logic              req_ry_wait_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] nor_addr_o,
    input  logic [DATA_W-1:0] nor_data_i,
    output logic [DATA_W-1:0] nor_data_o,
    output logic              nor_data_oe,
    input  logic              nor_ry_i,
    output logic              nor_ce_o,
    output logic              nor_oe_o,
    output logic              nor_we_o,
    output logic [2:0]        dbg_state_o
);

    // Request port handshake: a request is taken on any rising edge where req_i=1 and
    // the sequencer is idle (busy_o=0); requests while busy are dropped, never queued.
    // ack_o pulses for one cycle when the access finishes; rdata_o/err_o are valid with it.

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam bit PARAMS_OK = (T_SETUP >= 1) && (T_RD >= 1) && (T_WP >= 1) &&
                               (T_HOLD >= 1) && (T_BUSY >= 1) && (T_RY_TO >= 1);

    localparam int T_MAX_BASE = imax(imax(imax(T_SETUP, T_RD), imax(T_WP, T_HOLD)), T_BUSY);
`ifdef NOR_RY_TIMEOUT_EN
    localparam int T_MAX_SEL = imax(T_MAX_BASE, T_RY_TO);
`else
    localparam int T_MAX_SEL = T_MAX_BASE;
`endif
    localparam int T_MAX = PARAMS_OK ? T_MAX_SEL : 1;
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    // A non-positive timing collapses every phase to a single cycle instead of wrapping.
    localparam cnt_t LD_SETUP = PARAMS_OK ? cnt_t'(T_SETUP - 1) : '0;
    localparam cnt_t LD_RD    = PARAMS_OK ? cnt_t'(T_RD - 1)    : '0;
    localparam cnt_t LD_WP    = PARAMS_OK ? cnt_t'(T_WP - 1)    : '0;
    localparam cnt_t LD_HOLD  = PARAMS_OK ? cnt_t'(T_HOLD - 1)  : '0;
    localparam cnt_t LD_BUSY  = PARAMS_OK ? cnt_t'(T_BUSY - 1)  : '0;
`ifdef NOR_RY_TIMEOUT_EN
    localparam cnt_t LD_RYTO  = PARAMS_OK ? cnt_t'(T_RY_TO - 1) : '0;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_HOLD    = 3'd3,
        S_BUSYDLY = 3'd4,
        S_RYWAIT  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t            state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    logic              we_q, ry_wait_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ry_meta_q, ry_sync_q;
    logic              ce_q, oe_q, wen_q, data_oe_q, ack_q, busy_q;
    logic              ce_d, oe_d, wen_d, data_oe_d, ack_d, busy_d;
    logic              accept, cnt_zero, capture, we_nx, active_nx, strobe_nx;
`ifdef NOR_RY_TIMEOUT_EN
    logic              err_q, err_d;
`endif

    assign accept   = (state_q == S_IDLE) && req_i;
    assign cnt_zero = (cnt_q == '0);
    assign capture  = (state_q == S_STROBE) && !we_q && cnt_zero;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef NOR_RY_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    state_d = S_SETUP;
                    cnt_d   = LD_SETUP;
`ifdef NOR_RY_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_STROBE;
                    cnt_d   = we_q ? LD_WP : LD_RD;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            S_STROBE: begin
                if (cnt_zero) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
                    if (we_q && ry_wait_q) begin
                        state_d = S_BUSYDLY;
                        cnt_d   = LD_BUSY;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            S_BUSYDLY: begin
                if (cnt_zero) begin
                    state_d = S_RYWAIT;
`ifdef NOR_RY_TIMEOUT_EN
                    cnt_d   = LD_RYTO;
`else
                    cnt_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            S_RYWAIT: begin
                // Ready on the last allowed cycle still counts as success.
                if (ry_sync_q) begin
                    state_d = S_DONE;
`ifdef NOR_RY_TIMEOUT_EN
                end else if (cnt_zero) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pin values are registered from the next state so every output is a flop.
    always_comb begin
        we_nx     = accept ? req_we_i : we_q;
        active_nx = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        strobe_nx = (state_d == S_STROBE);
        ce_d      = !active_nx;
        oe_d      = !(strobe_nx && !we_nx);
        wen_d     = !(strobe_nx && we_nx);
        data_oe_d = active_nx && we_nx;
        ack_d     = (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            ry_wait_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ry_meta_q <= 1'b0;
            ry_sync_q <= 1'b0;
            ce_q      <= 1'b1;
            oe_q      <= 1'b1;
            wen_q     <= 1'b1;
            data_oe_q <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ry_meta_q <= nor_ry_i;
            ry_sync_q <= ry_meta_q;
            if (accept) begin
                we_q      <= req_we_i;
                ry_wait_q <= req_ry_wait_i;
                addr_q    <= req_addr_i;
                wdata_q   <= req_data_i;
            end
            if (capture) begin
                rdata_q <= nor_data_i;
            end
            ce_q      <= ce_d;
            oe_q      <= oe_d;
            wen_q     <= wen_d;
            data_oe_q <= data_oe_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
        end
    end

`ifdef NOR_RY_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign ack_o       = ack_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = busy_q;
    assign nor_addr_o  = addr_q;
    assign nor_data_o  = wdata_q;
    assign nor_data_oe = data_oe_q;
    assign nor_ce_o    = ce_q;
    assign nor_oe_o    = oe_q;
    assign nor_we_o    = wen_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nor_bus_sequencer.sv
// Bench for nor_bus_sequencer: vector table, hand-written corner sequences, randomized traffic.
module tb_nor_bus_sequencer;

  localparam int ADDR_W  = 26;
  localparam int DATA_W  = 16;
  localparam int T_SETUP = 2;
  localparam int T_RD    = 4;
  localparam int T_WP    = 3;
  localparam int T_HOLD  = 1;
  localparam int T_BUSY  = 5;
  localparam int T_RY_TO = 20;
`ifdef NOR_RY_TIMEOUT_EN
  localparam int RISE_MAX = 40;
`else
  localparam int RISE_MAX = 30;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset_i;
  logic              req_i, req_we_i, req_ry_wait_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_data_i;
  logic              ack_o, err_o, busy_o;
  logic [DATA_W-1:0] rdata_o;
  logic [ADDR_W-1:0] nor_addr_o;
  logic [DATA_W-1:0] nor_data_i, nor_data_o;
  logic              nor_data_oe, nor_ry_i;
  logic              nor_ce_o, nor_oe_o, nor_we_o;
  logic [2:0]        dbg_state_o;

  always #5 clk = ~clk;

  nor_bus_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_SETUP(T_SETUP), .T_RD(T_RD), .T_WP(T_WP),
    .T_HOLD(T_HOLD), .T_BUSY(T_BUSY), .T_RY_TO(T_RY_TO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .req_we_i(req_we_i),
    .req_ry_wait_i(req_ry_wait_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
    .nor_addr_o(nor_addr_o), .nor_data_i(nor_data_i), .nor_data_o(nor_data_o),
    .nor_data_oe(nor_data_oe), .nor_ry_i(nor_ry_i), .nor_ce_o(nor_ce_o),
    .nor_oe_o(nor_oe_o), .nor_we_o(nor_we_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_rdata_now();
    return (exp_q.size() > 0) ? exp_q[$] : '0;
  endfunction

  // ---------------- reference model (cycle 1 = first cycle after the accept edge) ----------------
  function automatic int strobe_len(input logic we);
    return we ? T_WP : T_RD;
  endfunction

  function automatic int active_len(input logic we);
    return T_SETUP + strobe_len(we) + T_HOLD;
  endfunction

  // Cycle in which ack_o is high. ry_rise: cycle during which RY/BY goes high (0 = never low).
  function automatic int model_raw_ack(input logic we, input logic ryw, input int ry_rise);
    int wait_start;
    int ready_ack;
    if (!(we && ryw)) return active_len(we) + 1;
    wait_start = active_len(we) + T_BUSY + 1;
    ready_ack  = (ry_rise + 3 > wait_start + 1) ? ry_rise + 3 : wait_start + 1;
    if (ry_rise == 0) ready_ack = wait_start + 1;
    return ready_ack;
  endfunction

  function automatic int model_ack(input logic we, input logic ryw, input int ry_rise);
    int a;
    a = model_raw_ack(we, ryw, ry_rise);
`ifdef NOR_RY_TIMEOUT_EN
    if (we && ryw && a > active_len(we) + T_BUSY + 1 + T_RY_TO)
      a = active_len(we) + T_BUSY + 1 + T_RY_TO;
`endif
    return a;
  endfunction

  function automatic logic model_err(input logic we, input logic ryw, input int ry_rise);
`ifdef NOR_RY_TIMEOUT_EN
    return we && ryw && (model_raw_ack(we, ryw, ry_rise) > active_len(we) + T_BUSY + 1 + T_RY_TO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic in_strobe(input logic we, input int c);
    return (c > T_SETUP) && (c <= T_SETUP + strobe_len(we));
  endfunction

  // {ce, oe, we, data_oe, busy}
  function automatic logic [4:0] model_pins(input logic we, input int c, input int ack_cycle);
    logic act;
    act = (c <= active_len(we));
    return {!act, !(in_strobe(we, c) && !we), !(in_strobe(we, c) && we), we && act, c <= ack_cycle};
  endfunction

  // ---------------- driver ----------------
  task automatic run_txn(input string name, input logic we, input logic ryw,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                         input logic [DATA_W-1:0] dq, input int ry_rise, input int exp_ack,
                         input logic [DATA_W-1:0] exp_rd, input logic exp_err);
    int ack_at, first_bad, waited, limit;
    logic [4:0] pins_act;
    logic [DATA_W-1:0] rd_at_ack;
    logic err_at_ack, busy_after;
    logic [ADDR_W-1:0] addr_after;
    ack_at = -1; first_bad = 0; waited = 0; limit = exp_ack + 4;
    rd_at_ack = 'x; err_at_ack = 1'bx; busy_after = 1'bx; addr_after = 'x;
    @(negedge clk);
    while (busy_o !== 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_idle_before"}, 32'(busy_o), 32'(0));
    req_i = 1'b1; req_we_i = we; req_ry_wait_i = ryw; req_addr_i = addr; req_data_i = data;
    nor_data_i = ~dq;
    if (ry_rise > 0) nor_ry_i = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == 1) req_i = 1'b0;
      if (c <= exp_ack) begin
        pins_act = {nor_ce_o, nor_oe_o, nor_we_o, nor_data_oe, busy_o};
        if ((pins_act !== model_pins(we, c, exp_ack) || nor_addr_o !== addr ||
             nor_data_o !== data) && first_bad == 0)
          first_bad = c;
      end
      if (ack_o === 1'b1) begin
        if (ack_at < 0) begin
          ack_at = c; rd_at_ack = rdata_o; err_at_ack = err_o;
        end else if (first_bad == 0) begin
          first_bad = c;
        end
      end
      if (c == ry_rise) nor_ry_i = 1'b1;
      nor_data_i = in_strobe(we, c) ? dq : ~dq;
      if (ack_at > 0 && c == ack_at + 1) begin
        busy_after = busy_o; addr_after = nor_addr_o;
        break;
      end
    end
    nor_ry_i = 1'b1;
    check({name, "_ack_cycle"}, 32'(ack_at), 32'(exp_ack));
    check({name, "_waveform_first_bad_cycle"}, 32'(first_bad), 32'(0));
    check({name, "_rdata"}, 32'(rd_at_ack), 32'(exp_rd));
    check({name, "_err"}, 32'(err_at_ack), 32'(exp_err));
    check({name, "_busy_after_ack"}, 32'(busy_after), 32'(0));
    check({name, "_addr_held_idle"}, 32'(addr_after), 32'(addr));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              we;
    logic              ryw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] dq;
    int                ry_rise;
    int                exp_ack;
    logic [DATA_W-1:0] exp_rd;
    logic              exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ack, a1, a2, addr_bad;
    logic we_r, ryw_r;
    logic [DATA_W-1:0] dq_r;
    int rise_r;

    vecs[0] = '{1'b0, 1'b0, 26'h0012345, 16'h0000, 16'hBEEF, 0,  8,  16'hBEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 26'h0000AAA, 16'h00AA, 16'h1111, 0,  7,  16'hBEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 26'h0000100, 16'h5555, 16'h2222, 16, 19, 16'hBEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 26'h0000200, 16'hAAAA, 16'h3333, 2,  13, 16'hBEEF, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 26'h3FFFFFF, 16'hFFFF, 16'h0000, 0,  8,  16'h0000, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 26'h0000000, 16'h0000, 16'hFFFF, 0,  8,  16'hFFFF, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 26'h1555555, 16'h0F0F, 16'h1234, 0,  8,  16'h1234, 1'b0};

    // reset
    reset_i = 1'b1; req_i = 1'b0; req_we_i = 1'b0; req_ry_wait_i = 1'b0;
    req_addr_i = '0; req_data_i = '0; nor_data_i = '0; nor_ry_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ce", 32'(nor_ce_o), 32'(1));
    check("reset_oe", 32'(nor_oe_o), 32'(1));
    check("reset_we", 32'(nor_we_o), 32'(1));
    check("reset_data_oe", 32'(nor_data_oe), 32'(0));
    check("reset_addr", 32'(nor_addr_o), 32'(0));
    check("reset_data_o", 32'(nor_data_o), 32'(0));
    check("reset_ack", 32'(ack_o), 32'(0));
    check("reset_err", 32'(err_o), 32'(0));
    check("reset_busy", 32'(busy_o), 32'(0));
    check("reset_rdata", 32'(rdata_o), 32'(0));
    reset_i = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (!vecs[i].we) exp_q.push_back(vecs[i].dq);
      run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].ryw, vecs[i].addr, vecs[i].data,
              vecs[i].dq, vecs[i].ry_rise, vecs[i].exp_ack, vecs[i].exp_rd, vecs[i].exp_err);
    end

    // RY/BY stuck low for a long time: timeout build gives err, otherwise ack once RY rises
    run_txn("ry_stuck", 1'b1, 1'b1, 26'h0000300, 16'hC3C3, 16'h4444, 60,
            model_ack(1'b1, 1'b1, 60), exp_rdata_now(), model_err(1'b1, 1'b1, 60));
    exp_q.push_back(16'h5678);
    run_txn("read_after_stuck", 1'b0, 1'b0, 26'h0000301, 16'h0000, 16'h5678, 0,
            model_ack(1'b0, 1'b0, 0), exp_rdata_now(), 1'b0);

    // req_i held high across the ack: exactly two back-to-back reads
    @(negedge clk);
    req_i = 1'b1; req_we_i = 1'b0; req_ry_wait_i = 1'b0; req_addr_i = 26'h0ABCDEF;
    req_data_i = 16'h0000; nor_data_i = 16'h9ABC;
    n_ack = 0; a1 = -1; a2 = -1;
    @(posedge clk);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (ack_o === 1'b1) begin
        n_ack++;
        if (n_ack == 1) a1 = c;
        else if (n_ack == 2) a2 = c;
      end
      if (c == 10) req_i = 1'b0;
    end
    exp_q.push_back(16'h9ABC);
    exp_q.push_back(16'h9ABC);
    check("b2b_ack_count", 32'(n_ack), 32'(2));
    check("b2b_first_ack", 32'(a1), 32'(model_ack(1'b0, 1'b0, 0)));
    check("b2b_second_ack", 32'(a2), 32'(2 * model_ack(1'b0, 1'b0, 0) + 1));
    check("b2b_rdata", 32'(rdata_o), 32'(exp_rdata_now()));

    // second req pulsed during STROBE of a write is dropped
    @(negedge clk);
    req_i = 1'b1; req_we_i = 1'b1; req_addr_i = 26'h0000777; req_data_i = 16'h7777;
    n_ack = 0; a1 = -1; addr_bad = 0;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) req_i = 1'b0;
      if (ack_o === 1'b1) begin
        n_ack++;
        if (a1 < 0) a1 = c;
      end
      if (nor_addr_o !== 26'h0000777) addr_bad++;
      if (c == 4) begin
        req_i = 1'b1; req_we_i = 1'b0; req_addr_i = 26'h0000888;
      end
      if (c == 5) req_i = 1'b0;
    end
    check("pulse_ack_count", 32'(n_ack), 32'(1));
    check("pulse_ack_cycle", 32'(a1), 32'(model_ack(1'b1, 1'b0, 0)));
    check("pulse_addr_kept", 32'(addr_bad), 32'(0));
    check("pulse_idle_end", 32'(busy_o), 32'(0));

    // reset during the write strobe
    @(negedge clk);
    req_i = 1'b1; req_we_i = 1'b1; req_ry_wait_i = 1'b0; req_addr_i = 26'h0000155;
    req_data_i = 16'h5A5A;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) req_i = 1'b0;
    end
    check("pre_reset_we_low", 32'(nor_we_o), 32'(0));
    reset_i = 1'b1;
    @(negedge clk);
    check("midreset_ce", 32'(nor_ce_o), 32'(1));
    check("midreset_we", 32'(nor_we_o), 32'(1));
    check("midreset_data_oe", 32'(nor_data_oe), 32'(0));
    check("midreset_ack", 32'(ack_o), 32'(0));
    check("midreset_busy", 32'(busy_o), 32'(0));
    check("midreset_addr", 32'(nor_addr_o), 32'(0));
    reset_i = 1'b0;
    exp_q.delete();
    n_ack = 0;
    repeat (12) begin
      @(negedge clk);
      if (ack_o === 1'b1) n_ack++;
    end
    check("midreset_no_ack", 32'(n_ack), 32'(0));
    exp_q.push_back(16'hCAFE);
    run_txn("read_after_reset", 1'b0, 1'b0, 26'h0012345, 16'h0000, 16'hCAFE, 0,
            model_ack(1'b0, 1'b0, 0), exp_rdata_now(), 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      we_r   = 1'($urandom_range(0, 1));
      ryw_r  = 1'($urandom_range(0, 1));
      dq_r   = DATA_W'($urandom);
      rise_r = $urandom_range(0, RISE_MAX);
      if (!we_r) exp_q.push_back(dq_r);
      run_txn($sformatf("rand%0d", i), we_r, ryw_r, ADDR_W'($urandom), DATA_W'($urandom),
              dq_r, rise_r, model_ack(we_r, ryw_r, rise_r), exp_rdata_now(),
              model_err(we_r, ryw_r, rise_r));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
